// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD datapath and its go/done driver.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_driver_if.sv
// Request stream, gcd_machine go/done link and response stream of gcd_driver.
interface gcd_driver_if import gcd_pkg::*; #(
  parameter int WIDTH = GCD_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             gcd_go;
  logic [WIDTH-1:0] gcd_in1;
  logic [WIDTH-1:0] gcd_in2;
  logic [WIDTH-1:0] gcd_out;
  logic             gcd_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_err;

  modport master (
    input  req_valid, req_a, req_b, gcd_out, gcd_done, rsp_ready,
    output req_ready, gcd_go, gcd_in1, gcd_in2, rsp_valid, rsp_gcd, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, gcd_out, gcd_done, rsp_ready,
    input  req_ready, gcd_go, gcd_in1, gcd_in2, rsp_valid, rsp_gcd, rsp_err
  );

endinterface

// File: rtl/gcd_req_fifo.sv
// Non-fall-through synchronous FIFO of operand pairs with registered full/empty.
module gcd_req_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Accept gates use the registered flags, so a push while full is dropped
  // even if a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rptr_q[AW-1:0]];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/gcd_driver.sv
// Initiator for gcd_machine: buffers operand pairs, runs one GCD at a time,
// resolves zero operands locally. Optional WAIT abort: GCD_DRV_TIMEOUT_EN.
module gcd_driver import gcd_pkg::*; #(
  parameter int WIDTH      = GCD_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input logic          clk,
  input logic          rst,
  gcd_driver_if.master bus
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
  logic             rsp_err_q, rsp_err_d;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_data;
  logic [WIDTH-1:0]   op_a, op_b;

  gcd_req_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.req_valid),
    .push_data_i ({bus.req_a, bus.req_b}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign op_a = fifo_data[2*WIDTH-1:WIDTH];
  assign op_b = fifo_data[WIDTH-1:0];

`ifdef GCD_DRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          to_expired;

  // The counter reaches TIMEOUT on the edge that leaves WAIT, so exactly
  // TIMEOUT WAIT cycles elapse before the abort response.
  assign to_expired = (to_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    rsp_gcd_d = rsp_gcd_q;
    rsp_err_d = rsp_err_q;
    fifo_pop  = 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (op_a != '0 && op_b != '0) begin
            in1_d   = op_a;
            in2_d   = op_b;
            state_d = LAUNCH;
          end else begin
            // Subtractive GCD never terminates on zero; answer here instead.
            rsp_gcd_d = (op_a == '0) ? op_b : op_a;
            rsp_err_d = (op_a == '0) && (op_b == '0);
            state_d   = RESP;
          end
        end
      end
      LAUNCH: begin
        // gcd_done is deliberately not looked at here: it may be a level
        // left over from the previous operation.
        state_d = WAIT;
`ifdef GCD_DRV_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (bus.gcd_done) begin
          rsp_gcd_d = bus.gcd_out;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end
`ifdef GCD_DRV_TIMEOUT_EN
        else if (to_expired) begin
          rsp_gcd_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
          to_cnt_d  = CW'(TIMEOUT);
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      in1_q     <= '0;
      in2_q     <= '0;
      rsp_gcd_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      rsp_gcd_q <= rsp_gcd_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.gcd_go    = (state_q == LAUNCH);
  assign bus.gcd_in1   = in1_q;
  assign bus.gcd_in2   = in2_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_gcd   = rsp_gcd_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/gcd_driver.md
# gcd_driver

Initiator for the GCD datapath's go/done handshake. Accepts operand pairs from an upstream valid/ready stream, buffers them in a small FIFO, launches one GCD computation at a time on the `gcd_machine` instance, captures the result on `done`, and returns it on a downstream valid/ready stream. Zero operands are resolved locally, because the subtractive GCD does not terminate on zero. Sits between the system bus adapter and `gcd_machine`.

## Interface
- `WIDTH`, 8: operand/result width; must match `gcd_machine`.
- `FIFO_DEPTH`, 4: request FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 1023: maximum WAIT cycles before abort (only with `GCD_DRV_TIMEOUT_EN`).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operand pair valid.
- `req_ready` out 1: FIFO not full.
- `req_a`, `req_b` in WIDTH: operands.
- `gcd_go` out 1: start pulse to `gcd_machine`.
- `gcd_in1`, `gcd_in2` out WIDTH: operands to `gcd_machine`; held stable from launch until the result is captured.
- `gcd_out` in WIDTH: result from `gcd_machine`.
- `gcd_done` in 1: completion from `gcd_machine`.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: downstream accepts the result.
- `rsp_gcd` out WIDTH: result.
- `rsp_err` out 1: result is invalid: gcd(0,0), or timeout.

## Operation
- Reset values: `req_ready`=1, `gcd_go`=0, `gcd_in1`/`gcd_in2`=0, `rsp_valid`=0, `rsp_gcd`=0, `rsp_err`=0. The FIFO is emptied and the FSM returns to IDLE. A reset mid-computation abandons that computation; `gcd_machine` shares `rst`.
- Push: on `req_valid && req_ready`. `req_ready` = !full, registered. A push while full is ignored, including when a pop occurs in the same cycle.
- FIFO is not fall-through: a push into an empty FIFO becomes poppable on the next cycle. Pointers carry one extra wrap bit, so full and empty are distinguished at wrap-around.
- FSM states are IDLE, LAUNCH, WAIT and RESP.
- IDLE, FIFO non-empty: pop, then branch on the popped operands.
  - a≠0 and b≠0: latch the operands into `gcd_in1`/`gcd_in2`, go to LAUNCH.
  - exactly one operand is 0: `rsp_gcd` = the nonzero operand, `rsp_err`=0, go to RESP.
  - both operands are 0: `rsp_gcd`=0, `rsp_err`=1, go to RESP.
- LAUNCH: `gcd_go`=1 for exactly this cycle, then go to WAIT.
- WAIT: `gcd_done` is sampled from the first WAIT cycle onward. On `gcd_done`=1, capture `gcd_out` into `rsp_gcd`, set `rsp_err`=0, go to RESP.
- RESP: `rsp_valid`=1. `rsp_gcd` and `rsp_err` are stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Only one request is in flight. No pop occurs outside IDLE.

## Timing
- Normal path:
  - pop in cycle P.
  - `gcd_go` high in P+1.
  - done first seen in cycle D ≥ P+2.
  - `rsp_valid` high from D+1.
- Zero bypass: pop in P, `rsp_valid` high from P+1.
- Back-to-back: a handshake in RESP at cycle R allows the next pop at R+1. Minimum spacing is 2 cycles per bypassed request and 4 per computed request.
- Any `gcd_done` level present during LAUNCH is ignored, so a done held over from the previous operation cannot complete the next one.
- `rsp_ready` held high does not shorten RESP below 1 cycle.
- Push and pop in the same cycle: the count is unchanged. In a simultaneous push/pop at wrap-around, both pointers wrap independently.

## Configuration
- `GCD_DRV_TIMEOUT_EN` defined:
  - WAIT runs a counter of width clog2(TIMEOUT+1), cleared on entry to WAIT.
  - When the counter reaches `TIMEOUT` without `gcd_done`: go to RESP with `rsp_gcd`=0 and `rsp_err`=1.
  - The next launch is unaffected.
- `GCD_DRV_TIMEOUT_EN` undefined: no counter, and WAIT waits indefinitely.

## Structure
- `gcd_pkg`: FSM state enum (IDLE, LAUNCH, WAIT, RESP) and the default `WIDTH` constant, shared with the GCD datapath.
- Sub-module `gcd_req_fifo`: synchronous FIFO of {a,b} pairs, 2×WIDTH wide and `FIFO_DEPTH` deep, with registered full/empty. The FSM and response register live in `gcd_driver`.

## Test plan
- Push (48,18) with a `gcd_machine` model → `gcd_go` one cycle after the pop, operands held through WAIT, `rsp_gcd`=6, `rsp_err`=0, `rsp_valid` the cycle after done.
- Push (0,35), then (0,0) → `rsp_gcd`=35 with err=0, then `rsp_gcd`=0 with err=1; `gcd_go` never asserted; each response 1 cycle after its pop.
- Hold `rsp_ready`=0 and push 5 pairs with FIFO_DEPTH=4 → `req_ready` drops after 4 entries are buffered. Release `rsp_ready` → all 5 results return in order, including across pointer wrap.
- Model keeps `gcd_done` high after the previous op → a new launch ignores done in LAUNCH and captures only the new result.
- Assert `rst` low during WAIT → all outputs return to reset values immediately and the FIFO reads empty. After release, a new request completes normally.
- With `GCD_DRV_TIMEOUT_EN` and TIMEOUT=15, model never asserts done → `rsp_err`=1 and `rsp_gcd`=0 exactly 15 cycles after entering WAIT; the next request succeeds.
